// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation codes, HI/LO access codes,
// default latencies and the FSM state type.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  localparam logic [1:0] MUWE_NONE = 2'd0;
  localparam logic [1:0] MUWE_HI   = 2'd1;
  localparam logic [1:0] MUWE_LO   = 2'd2;

  localparam logic [1:0] MURE_NONE = 2'd0;
  localparam logic [1:0] MURE_HI   = 2'd1;
  localparam logic [1:0] MURE_LO   = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_mdu_calc.sv
// Combinational result generator for mult/multu/div/divu, producing {hi, lo}.
// Signed forms go through sign/magnitude so one unsigned multiplier and divider serve both.
module mdu_calc
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  multctrl,
  output logic [63:0] result
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] div0_lo;

  assign signed_op = (multctrl == MD_MULT) || (multctrl == MD_DIV);
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;

  assign prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
  assign prod     = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;

  // Divisor forced non-zero so the divider never sees x/0; the b==0 result is muxed below.
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  assign div0_lo = ((multctrl == MD_DIV) && a[31]) ? 32'd1 : 32'hFFFF_FFFF;

  always_comb begin
    result = 64'd0;
    case (multctrl)
      MD_MULT, MD_MULTU: result = prod;
      MD_DIV, MD_DIVU:   result = (b == 32'd0) ? {a, div0_lo} : {rem, quot};
      default:           result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit top: FSM, latency down-counter, HI/LO and pending-result registers.
// Optional MDU_DIV0_GUARD_EN: divide by zero leaves HI/LO untouched at completion.
//
//   state   | meaning
//   ST_IDLE | no operation in flight, busy=0, start accepted
//   ST_RUN  | result held in *_pend, counter counting down, busy=1
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  multctrl,
  input  logic        start,
  input  logic [1:0]  muwe,
  input  logic [1:0]  mure,
  output logic        busy,
  output logic [31:0] mu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d;
  logic [31:0]      lo_pend_q, lo_pend_d;
  logic             keep_q, keep_d;
  logic [63:0]      calc_result;
  logic             launch;
  logic             div0_keep;

  mdu_calc u_calc (
    .a        (a),
    .b        (b),
    .multctrl (multctrl),
    .result   (calc_result)
  );

`ifdef MDU_DIV0_GUARD_EN
  assign div0_keep = is_div_op(multctrl) && (b == 32'd0);
`else
  assign div0_keep = 1'b0;
`endif

  assign launch = start && is_valid_op(multctrl);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    keep_d    = keep_q;

    if (muwe == MUWE_HI) hi_d = a;
    if (muwe == MUWE_LO) lo_d = a;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_RUN;
          cnt_d     = is_div_op(multctrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          hi_pend_d = calc_result[63:32];
          lo_pend_d = calc_result[31:0];
          keep_d    = div0_keep;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          // Completion takes priority over a same-cycle muwe write.
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!keep_q) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      keep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      keep_q    <= keep_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mu_out = 32'd0;
    case (mure)
      MURE_HI: mu_out = hi_q;
      MURE_LO: mu_out = lo_q;
      default: mu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random operations against an
// arithmetic reference model of HI/LO, including reset-in-flight and divide by zero.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  multctrl;
  logic        start;
  logic [1:0]  muwe;
  logic [1:0]  mure;
  logic        busy;
  logic [31:0] mu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .multctrl (multctrl),
    .start    (start),
    .muwe     (muwe),
    .mure     (mure),
    .busy     (busy),
    .mu_out   (mu_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_op(input int op, input logic [31:0] av,
                                           input logic [31:0] bv, input logic [31:0] hi_old,
                                           input logic [31:0] lo_old);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     q;
    logic [63:0]     r;
    logic [63:0]     res;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'd0, av};
    ub  = {32'd0, bv};
    res = 64'd0;
    if ((op == 3 || op == 4) && bv == 32'd0) begin
`ifdef MDU_DIV0_GUARD_EN
      res = {hi_old, lo_old};
`else
      if (op == 3 && sa < 0) res = {av, 32'd1};
      else                   res = {av, 32'hFFFF_FFFF};
`endif
    end else begin
      case (op)
        1: res = sa * sb;
        2: res = ua * ub;
        3: begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
        4: begin q = ua / ub; r = ua % ub; res = {r[31:0], q[31:0]}; end
        default: res = {hi_old, lo_old};
      endcase
    end
    return res;
  endfunction

  task automatic run_op(input int op, input logic [31:0] av, input logic [31:0] bv,
                        input string name);
    logic [63:0] exp;
    int          n;
    exp      = model_op(op, av, bv, m_hi, m_lo);
    n        = (op >= 3) ? 10 : 5;
    multctrl = 3'(op);
    a        = av;
    b        = bv;
    start    = 1'b1;
    step();
    start    = 1'b0;
    multctrl = 3'd0;
    a        = $urandom;
    b        = $urandom;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: busy=%0b expected 1", name, i + 1, busy);
      end
      vectors++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL %s early hi/lo cycle %0d: got %h/%h expected %h/%h",
                 name, i + 1, hi, lo, m_hi, m_lo);
      end
      step();
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done busy: busy=%0b expected 0", name, busy);
    end
    vectors++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
               name, av, bv, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    muwe = 2'd1; a = hv; step();
    muwe = 2'd2; a = lv; step();
    muwe = 2'd0;
    m_hi = hv;
    m_lo = lv;
    vectors++;
    if (hi !== hv || lo !== lv) begin
      errors++;
      $display("FAIL preload: got %h/%h expected %h/%h", hi, lo, hv, lv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; a = '0; b = '0; multctrl = '0; start = 1'b0; muwe = '0; mure = '0;
    step(); step();
    reset = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mu_out !== 32'd0) begin
      errors++;
      $display("FAIL reset state: busy=%0b hi=%h lo=%h mu_out=%h expected 0/0/0/0",
               busy, hi, lo, mu_out);
    end
  endtask

  task automatic test_mult();
    run_op(1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(2, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    run_op(1, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
    for (int i = 0; i < 6; i++)
      run_op(($urandom_range(0, 1) == 0) ? 1 : 2, $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div();
    run_op(3, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(4, 32'd7, 32'd2, "divu_7_2");
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
    run_op(3, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    for (int i = 0; i < 6; i++)
      run_op(($urandom_range(0, 1) == 0) ? 3 : 4, $urandom,
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom, "div_rand");
  endtask

  task automatic test_mthi_mflo();
    muwe = 2'd1; a = 32'd1234; step();
    muwe = 2'd0; mure = 2'd1; #1;
    vectors++;
    if (mu_out !== 32'd1234) begin
      errors++;
      $display("FAIL mfhi: mu_out=%h expected %h", mu_out, 32'd1234);
    end
    mure = 2'd0; #1;
    vectors++;
    if (mu_out !== 32'd0) begin
      errors++;
      $display("FAIL mure_none: mu_out=%h expected 0", mu_out);
    end
    m_hi = 32'd1234;
    muwe = 2'd2; a = 32'hCAFE_0001; step();
    muwe = 2'd0; mure = 2'd2; #1;
    m_lo = 32'hCAFE_0001;
    vectors++;
    if (mu_out !== m_lo || hi !== m_hi) begin
      errors++;
      $display("FAIL mflo: mu_out=%h hi=%h expected %h/%h", mu_out, hi, m_lo, m_hi);
    end
    mure = 2'd0;
  endtask

  task automatic test_muwe_overlap();
    logic [63:0] exp;
    logic [31:0] wv;
    // muwe and start together: write lands and the op launches with the same a
    write_hilo(32'h1111_1111, 32'h2222_2222);
    wv   = 32'h0000_0009;
    exp  = model_op(1, wv, 32'd4, m_hi, m_lo);
    muwe = 2'd2; a = wv; b = 32'd4; multctrl = 3'd1; start = 1'b1;
    step();
    muwe = 2'd0; start = 1'b0; multctrl = 3'd0;
    vectors++;
    if (busy !== 1'b1 || lo !== wv) begin
      errors++;
      $display("FAIL muwe_with_start: busy=%0b lo=%h expected 1/%h", busy, lo, wv);
    end
    step();
    muwe = 2'd1; a = 32'hDEAD_BEEF;
    step();
    muwe = 2'd0;
    vectors++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL muwe_in_run: hi=%h busy=%0b expected deadbeef/1", hi, busy);
    end
    step(); step(); step();
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    vectors++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL overwrite_after_muwe: busy=%0b hi=%h lo=%h expected 0/%h/%h",
               busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_noop();
    multctrl = 3'd0; start = 1'b1; a = $urandom; b = $urandom;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL noop_start: busy=%0b hi=%h lo=%h expected 0/%h/%h",
               busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_during_run();
    write_hilo(32'd11, 32'd22);
    multctrl = 3'd3; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    step();
    start = 1'b0; multctrl = 3'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_run: busy=%0b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) step();
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_discard: busy=%0b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_div0();
    write_hilo(32'd5, 32'd6);
    run_op(3, 32'd100, 32'd0, "div0_pos");
    write_hilo(32'd5, 32'd6);
    run_op(3, 32'hFFFF_FF00, 32'd0, "div0_neg");
    write_hilo(32'd7, 32'd8);
    run_op(4, 32'h8000_0001, 32'd0, "divu0");
  endtask

  task automatic test_back_to_back();
    int op;
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(1, 4);
      run_op(op, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, "b2b_rand");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mflo();
    test_muwe_overlap();
    test_noop();
    test_reset_during_run();
    test_div0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
